// File: rtl/legv8_enc_pkg.sv
// legv8_enc_pkg: op codes, opcodes, field widths, FSM states and the LEGv8 field packer.
package legv8_enc_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_LSL, OP_LSR,
    OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI, OP_LDUR, OP_STUR, OP_B, OP_CBZ, OP_ILL
  } op_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;
  localparam int OPW  = 4;
  localparam int RW   = 5;
  localparam int SHW  = 6;
  localparam int IMMW = 26;
  localparam logic [10:0] OPC_ADD  = 11'h458, OPC_SUB  = 11'h658, OPC_AND = 11'h450,
                          OPC_ORR  = 11'h550, OPC_EOR  = 11'h650, OPC_LSL = 11'h69B,
                          OPC_LSR  = 11'h69A, OPC_LDUR = 11'h7C2, OPC_STUR = 11'h7C0;
  localparam logic [9:0]  OPC_ADDI = 10'h244, OPC_SUBI = 10'h344, OPC_ANDI = 10'h248,
                          OPC_ORRI = 10'h2C8;
  localparam logic [5:0]  OPC_B    = 6'h05;
  localparam logic [7:0]  OPC_CBZ  = 8'hB4;
  typedef struct packed {
    logic [31:0] word;
    logic        illegal;
    logic        bad_imm;
  } enc_t;
  // I-type immediates are unsigned; D and CB are signed, so upper bits must replicate the field sign
  function automatic enc_t encode(input op_e op, input logic [RW-1:0] rd, rn, rm,
                                  input logic [SHW-1:0] sh, input logic [IMMW-1:0] imm);
    enc_t e;
    e = '0;
    case (op)
      OP_ADD:  e.word = {OPC_ADD, rm, sh, rn, rd};
      OP_SUB:  e.word = {OPC_SUB, rm, sh, rn, rd};
      OP_AND:  e.word = {OPC_AND, rm, sh, rn, rd};
      OP_ORR:  e.word = {OPC_ORR, rm, sh, rn, rd};
      OP_EOR:  e.word = {OPC_EOR, rm, sh, rn, rd};
      OP_LSL:  e.word = {OPC_LSL, rm, sh, rn, rd};
      OP_LSR:  e.word = {OPC_LSR, rm, sh, rn, rd};
      OP_ADDI: e.word = {OPC_ADDI, imm[11:0], rn, rd};
      OP_SUBI: e.word = {OPC_SUBI, imm[11:0], rn, rd};
      OP_ANDI: e.word = {OPC_ANDI, imm[11:0], rn, rd};
      OP_ORRI: e.word = {OPC_ORRI, imm[11:0], rn, rd};
      OP_LDUR: e.word = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
      OP_STUR: e.word = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
      OP_B:    e.word = {OPC_B, imm};
      OP_CBZ:  e.word = {OPC_CBZ, imm[18:0], rd};
      default: e.illegal = 1'b1;
    endcase
    case (op)
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI: e.bad_imm = |imm[25:12];
      OP_LDUR, OP_STUR: e.bad_imm = imm[25:8] != {18{imm[8]}};
      OP_CBZ: e.bad_imm = imm[25:18] != {8{imm[18]}};
      default: e.bad_imm = 1'b0;
    endcase
    return e;
  endfunction
endpackage

// File: rtl/legv8_instr_encoder_if.sv
// legv8_instr_encoder_if: symbolic-instruction input stream and instruction-memory write port.
interface legv8_instr_encoder_if
  import legv8_enc_pkg::*;
#(parameter int ADDR_W = 32);
  logic              in_valid, in_ready, in_last;
  logic [OPW-1:0]    in_op;
  logic [RW-1:0]     in_rd, in_rn, in_rm;
  logic [SHW-1:0]    in_shamt;
  logic [IMMW-1:0]   in_imm;
  logic              imem_we, imem_stall;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  modport master (
    output in_valid, in_op, in_rd, in_rn, in_rm, in_shamt, in_imm, in_last, imem_stall,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
  modport slave (
    input  in_valid, in_op, in_rd, in_rn, in_rm, in_shamt, in_imm, in_last, imem_stall,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/legv8_enc_fifo.sv
// legv8_enc_fifo: synchronous FIFO with a combinational head and full/empty flags.
module legv8_enc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr,
  input  logic         rd,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wp_q, rp_q;
  assign empty = wp_q == rp_q;
  assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign dout  = mem_q[rp_q[AW-1:0]];
  always_ff @(posedge clk)
    if (wr && !full) mem_q[wp_q[AW-1:0]] <= din;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (wr && !full) wp_q <= wp_q + (AW+1)'(1);
      if (rd && !empty) rp_q <= rp_q + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/legv8_instr_encoder.sv
// legv8_instr_encoder: packs symbolic LEGv8 instructions into words and writes them
// sequentially to instruction memory through a FIFO and a stall-tolerant output register.
module legv8_instr_encoder
  import legv8_enc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  legv8_instr_encoder_if.slave  bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err_illegal,
  output logic                  err_imm,
  output logic [ADDR_W-1:0]     words
);
  state_e            state_q;
  logic [ADDR_W-1:0] addr_q, words_q;
  logic [31:0]       wdata_q, head;
  logic              we_q, busy_q, done_q, ill_q, imm_q;
  logic              acc, push, adv, pop, full, empty;
  enc_t              enc;
  assign enc          = encode(op_e'(bus.in_op), bus.in_rd, bus.in_rn, bus.in_rm, bus.in_shamt, bus.in_imm);
  assign bus.in_ready = (state_q == S_RUN) && !full;
  assign acc          = bus.in_valid && bus.in_ready;
  assign push         = acc && !enc.illegal;
  // The output register advances when idle or when its current word is being taken
  assign adv          = !we_q || !bus.imem_stall;
  assign pop          = adv && !empty;
  legv8_enc_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk(clk), .rst_n(rst_n), .wr(push), .rd(pop), .din(enc.word),
    .dout(head), .full(full), .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      words_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
      imm_q   <= 1'b0;
    end else begin
      if (adv) we_q <= !empty;
      if (pop) wdata_q <= head;
      if (we_q && !bus.imem_stall) begin
        addr_q  <= addr_q + ADDR_W'(4);
        words_q <= words_q + ADDR_W'(1);
      end
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          state_q <= S_RUN;
          busy_q  <= 1'b1;
          addr_q  <= base_addr & ~ADDR_W'(3);
          words_q <= '0;
          ill_q   <= 1'b0;
          imm_q   <= 1'b0;
        end
        S_RUN: if (acc) begin
          ill_q <= ill_q | enc.illegal;
          imm_q <= imm_q | enc.bad_imm;
          if (bus.in_last) state_q <= S_DRAIN;
        end
        S_DRAIN: if (empty && !we_q) begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_illegal    = ill_q;
  assign err_imm        = imm_q;
  assign words          = words_q;
endmodule

// File: tb/tb_legv8_instr_encoder.sv
// tb_legv8_instr_encoder: table-driven vectors with an address/word scoreboard on the memory port.
module tb_legv8_instr_encoder;
  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rd, rn, rm;
    logic [5:0]  sh;
    logic [25:0] imm;
    logic [31:0] word;
    bit          ill, bad;
  } vec_t;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] base_addr = '0, words;
  logic        busy, done, err_illegal, err_imm;
  int          checks = 0, errors = 0, nwrites = 0;
  logic [63:0] sb [$];
  logic [31:0] exp_addr;
  vec_t        tv [22];
  legv8_instr_encoder_if #(.ADDR_W(32)) bus ();
  legv8_instr_encoder #(.ADDR_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .bus(bus),
    .busy(busy), .done(done), .err_illegal(err_illegal), .err_imm(err_imm), .words(words)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic vec_t mk(input int op, rd, rn, rm, sh, imm, input logic [31:0] word,
                              input bit ill, bad);
    vec_t v;
    v.op = 4'(op); v.rd = 5'(rd); v.rn = 5'(rn); v.rm = 5'(rm); v.sh = 6'(sh);
    v.imm = 26'(imm); v.word = word; v.ill = ill; v.bad = bad;
    return v;
  endfunction
  always @(negedge clk)
    if (rst_n && bus.imem_we && !bus.imem_stall) begin
      nwrites++;
      if (sb.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("wr_addr", {32'h0, bus.imem_addr}, {32'h0, e[63:32]});
        chk("wr_data", {32'h0, bus.imem_wdata}, {32'h0, e[31:0]});
      end
    end
  task automatic begin_load(input logic [31:0] base);
    start = 1'b1;
    base_addr = base;
    @(posedge clk);
    #1 start = 1'b0;
    exp_addr = {base[31:2], 2'b00};
  endtask
  task automatic send(input vec_t v, input bit last);
    bit ok, r;
    ok = 0;
    bus.in_valid = 1'b1; bus.in_op = v.op; bus.in_rd = v.rd; bus.in_rn = v.rn;
    bus.in_rm = v.rm; bus.in_shamt = v.sh; bus.in_imm = v.imm; bus.in_last = last;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      r = bus.in_ready;
      @(posedge clk);
      if (r) ok = 1;
    end
    if (ok && !v.ill) begin
      sb.push_back({exp_addr, v.word});
      exp_addr = exp_addr + 32'd4;
    end
    #1 bus.in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask
  task automatic wait_done(input int w, input bit ill, input bit bad);
    bit got;
    got = 0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    chk("done_seen", 64'(got), 1);
    chk("words", {32'h0, words}, 64'(w));
    chk("err_illegal", 64'(err_illegal), 64'(ill));
    chk("err_imm", 64'(err_imm), 64'(bad));
    chk("sb_empty", 64'(sb.size()), 0);
    @(negedge clk);
    chk("done_pulse_busy", {62'h0, done, busy}, 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    bit saw_full;
    logic [31:0] ca, cd;
    int n0;
    tv[0]  = mk(0, 1, 2, 3, 0, 0, 32'h8B030041, 0, 0);
    tv[1]  = mk(1, 4, 5, 6, 0, 0, 32'hCB0600A4, 0, 0);
    tv[2]  = mk(2, 7, 8, 9, 0, 0, 32'h8A090107, 0, 0);
    tv[3]  = mk(3, 10, 11, 12, 0, 0, 32'hAA0C016A, 0, 0);
    tv[4]  = mk(4, 1, 2, 3, 0, 0, 32'hCA030041, 0, 0);
    tv[5]  = mk(5, 1, 2, 0, 4, 0, 32'hD3601041, 0, 0);
    tv[6]  = mk(6, 3, 4, 0, 63, 0, 32'hD340FC83, 0, 0);
    tv[7]  = mk(7, 9, 9, 0, 0, 1, 32'h91000529, 0, 0);
    tv[8]  = mk(8, 2, 3, 0, 0, 4095, 32'hD13FFC62, 0, 0);
    tv[9]  = mk(9, 1, 1, 0, 0, 255, 32'h9203FC21, 0, 0);
    tv[10] = mk(10, 0, 31, 0, 0, 5, 32'hB20017E0, 0, 0);
    tv[11] = mk(11, 5, 6, 31, 63, 8, 32'hF84080C5, 0, 0);
    tv[12] = mk(12, 1, 2, 0, 0, -256, 32'hF8100041, 0, 0);
    tv[13] = mk(13, 5, 6, 7, 8, 3, 32'h14000003, 0, 0);
    tv[14] = mk(13, 0, 0, 0, 0, -1, 32'h17FFFFFF, 0, 0);
    tv[15] = mk(14, 0, 9, 3, 0, -2, 32'hB4FFFFC0, 0, 0);
    tv[16] = mk(14, 7, 0, 0, 0, 262143, 32'hB47FFFE7, 0, 0);
    tv[17] = mk(7, 3, 3, 0, 0, 4096, 32'h91000063, 0, 1);
    tv[18] = mk(7, 0, 0, 0, 0, -1, 32'h913FFC00, 0, 1);
    tv[19] = mk(11, 0, 0, 0, 0, 256, 32'hF8500000, 0, 1);
    tv[20] = mk(14, 0, 0, 0, 0, 262144, 32'hB4800000, 0, 1);
    tv[21] = mk(15, 1, 2, 3, 0, 0, 32'h0, 1, 0);
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rd = '0; bus.in_rn = '0; bus.in_rm = '0;
    bus.in_shamt = '0; bus.in_imm = '0; bus.in_last = 1'b0; bus.imem_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", {58'h0, busy, done, err_illegal, err_imm, bus.in_ready, bus.imem_we}, 0);
    chk("rst_words", {32'h0, words}, 0);
    chk("rst_addr", {32'h0, bus.imem_addr}, 0);
    chk("rst_wdata", {32'h0, bus.imem_wdata}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    begin_load(32'h40);
    chk("busy_after_start", 64'(busy), 1);
    send(tv[0], 1);
    chk("latency_we_low", 64'(bus.imem_we), 0);
    @(posedge clk);
    #1 chk("latency_we_high", 64'(bus.imem_we), 1);
    wait_done(1, 0, 0);
    for (int i = 0; i < 22; i++) begin
      begin_load(32'h200);
      send(tv[i], 1);
      wait_done(tv[i].ill ? 0 : 1, tv[i].ill, tv[i].bad);
    end
    begin_load(32'h103);
    for (int i = 0; i < 17; i++) send(tv[i], i == 16);
    wait_done(17, 0, 0);
    begin_load(32'h80);
    send(tv[21], 0);
    send(tv[17], 1);
    wait_done(1, 1, 1);
    begin_load(32'h90);
    chk("errs_cleared", {61'h0, err_illegal, err_imm, busy}, 1);
    send(tv[7], 1);
    wait_done(1, 0, 0);
    begin_load(32'hFFFFFFFC);
    send(tv[0], 0);
    start = 1'b1; base_addr = 32'h500;
    @(posedge clk);
    #1 start = 1'b0;
    send(tv[1], 1);
    wait_done(2, 0, 0);
    saw_full = 0;
    bus.imem_stall = 1'b1;
    begin_load(32'h300);
    fork
      for (int i = 0; i < 6; i++) send(tv[i], i == 5);
      begin
        for (int c = 0; c < 50 && !bus.imem_we; c++) @(negedge clk);
        ca = bus.imem_addr;
        cd = bus.imem_wdata;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          chk("hold_we", 64'(bus.imem_we), 1);
          chk("hold_addr", {32'h0, bus.imem_addr}, {32'h0, ca});
          chk("hold_data", {32'h0, bus.imem_wdata}, {32'h0, cd});
          if (!bus.in_ready) saw_full = 1;
        end
        bus.imem_stall = 1'b0;
      end
    join
    chk("in_ready_dropped", 64'(saw_full), 1);
    wait_done(6, 0, 0);
    bus.imem_stall = 1'b1;
    begin_load(32'h400);
    for (int i = 0; i < 5; i++) send(tv[i], 0);
    chk("full_in_ready", 64'(bus.in_ready), 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_flags", {58'h0, busy, done, err_illegal, err_imm, bus.in_ready, bus.imem_we}, 0);
    chk("mid_rst_words", {32'h0, words}, 0);
    chk("mid_rst_addr", {32'h0, bus.imem_addr}, 0);
    chk("mid_rst_wdata", {32'h0, bus.imem_wdata}, 0);
    sb.delete();
    n0 = nwrites;
    bus.imem_stall = 1'b0;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("no_writes_after_rst", 64'(nwrites), 64'(n0));
    chk("idle_after_rst", {62'h0, busy, bus.imem_we}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
